mult_c3x3_result_unpacker: RTL and testbench

//  Consumer end of the fracturable 9x9 C3x3 multiplier output bus. Takes one registered 18-bit

---
 rtl/mult_c3x3_result_unpacker.sv | 187 ++++++++++++++++++
 tb/tb_mult_c3x3_result_unpacker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_c3x3_result_unpacker.sv
// Splits one packed C3x3 product word into sign/zero-extended lane beats on a valid/ready stream.
// Optional feature macro: UNPACKER_LANE_SUM_EN adds out_sum_o, the running sum of a word's lanes.
//
// state  | meaning
// S_IDLE | no word held, ready to accept
// S_EMIT | emitting lanes of the latched word, lane_q is the current beat
module mult_c3x3_result_unpacker #(
    parameter int W_IN  = 18,
    parameter int W_OUT = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W_IN-1:0]  in_data_i,
    input  logic [1:0]       in_mode_i,
    input  logic             in_sign_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OUT-1:0] out_data_o,
    output logic [1:0]       out_lane_o,
    output logic             out_last_o,
    output logic             err_mode_o
`ifdef UNPACKER_LANE_SUM_EN
    ,
    output logic [W_OUT+1:0] out_sum_o
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W_IN-1:0]  data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;
    logic [1:0]       lane_q, lane_d;
    logic             err_q, err_d;

    logic [1:0]       last_lane;
    logic [W_OUT-1:0] field;
    logic [4:0]       field_w;
    logic             field_msb;
    logic [W_OUT-1:0] lane_ext;
    logic             out_valid;
    logic             is_last;
    logic             beat_fire;
    logic             in_ready;
    logic             accept;

    // Field select for the current lane; mode_q never holds 3 (folded to full width on accept).
    always_comb begin
        last_lane = 2'd0;
        field     = W_OUT'(data_q);
        field_w   = 5'd18;
        field_msb = data_q[17];
        case (mode_q)
            2'd1: begin
                last_lane = 2'd1;
                if (lane_q == 2'd0) begin
                    field     = W_OUT'(data_q[7:0]);
                    field_w   = 5'd8;
                    field_msb = data_q[7];
                end else begin
                    field     = W_OUT'(data_q[17:8]);
                    field_w   = 5'd10;
                    field_msb = data_q[17];
                end
            end
            2'd2: begin
                last_lane = 2'd3;
                case (lane_q)
                    2'd0: begin
                        field     = W_OUT'(data_q[3:0]);
                        field_w   = 5'd4;
                        field_msb = data_q[3];
                    end
                    2'd1: begin
                        field     = W_OUT'(data_q[7:4]);
                        field_w   = 5'd4;
                        field_msb = data_q[7];
                    end
                    2'd2: begin
                        field     = W_OUT'(data_q[13:8]);
                        field_w   = 5'd6;
                        field_msb = data_q[13];
                    end
                    default: begin
                        field     = W_OUT'(data_q[17:14]);
                        field_w   = 5'd4;
                        field_msb = data_q[17];
                    end
                endcase
            end
            default: begin
                last_lane = 2'd0;
            end
        endcase
        lane_ext = field | ((sign_q && field_msb) ? ({W_OUT{1'b1}} << field_w) : '0);
    end

    assign out_valid = (state_q == S_EMIT);
    assign is_last   = out_valid && (lane_q == last_lane);
    assign beat_fire = out_valid && out_ready_i;
    assign in_ready  = !out_valid || (beat_fire && is_last);
    assign accept    = in_valid_i && in_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        lane_d  = lane_q;
        err_d   = err_q;
        if (accept) begin
            state_d = S_EMIT;
            data_d  = in_data_i;
            mode_d  = (in_mode_i == 2'd3) ? 2'd0 : in_mode_i;
            sign_d  = in_sign_i;
            lane_d  = 2'd0;
            if (in_mode_i == 2'd3) begin
                err_d = 1'b1;
            end
        end else if (beat_fire) begin
            if (is_last) begin
                state_d = S_IDLE;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end
    end

    // Clearing data_q/mode_q on reset is what forces out_data_o to zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            mode_q  <= 2'd0;
            sign_q  <= 1'b0;
            lane_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign out_data_o  = lane_ext;
    assign out_lane_o  = lane_q;
    assign out_last_o  = is_last;
    assign err_mode_o  = err_q;

`ifdef UNPACKER_LANE_SUM_EN
    logic [W_OUT+1:0] sum_q, sum_d;
    logic [W_OUT+1:0] lane_wide;

    // sum_q holds earlier lanes; the current lane is added combinationally so the total lands on out_last.
    always_comb begin
        lane_wide = sign_q ? {{2{lane_ext[W_OUT-1]}}, lane_ext} : {2'b00, lane_ext};
        sum_d     = sum_q;
        if (accept) begin
            sum_d = '0;
        end else if (beat_fire) begin
            sum_d = sum_q + lane_wide;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_sum_o = sum_q + lane_wide;
`endif

endmodule

// File: tb/tb_mult_c3x3_result_unpacker.sv
// Self-checking bench for mult_c3x3_result_unpacker: directed cases then random traffic against a lane-list model.
module tb_mult_c3x3_result_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic [1:0]  in_mode;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        err_mode;
`ifdef UNPACKER_LANE_SUM_EN
    logic [19:0] out_sum;
`endif

    always #5 clk = ~clk;

    mult_c3x3_result_unpacker #(.W_IN(18), .W_OUT(18)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mode_i   (in_mode),
        .in_sign_i   (in_sign),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_lane_o  (out_lane),
        .out_last_o  (out_last),
        .err_mode_o  (err_mode)
`ifdef UNPACKER_LANE_SUM_EN
        ,
        .out_sum_o   (out_sum)
`endif
    );

    typedef struct {
        logic [17:0] data;
        logic [1:0]  lane;
        bit          last;
        logic [19:0] sum;
    } beat_t;

    beat_t q[$];
    bit    err_m;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected beats from the lane layout table, using plain integer arithmetic.
    task automatic push_word(input logic [17:0] d, input logic [1:0] m, input bit s);
        int    lo[4];
        int    w[4];
        int    n;
        int    f;
        int    acc;
        beat_t b;
        case (m)
            2'd1: begin
                n = 2;
                lo[0] = 0; w[0] = 8;
                lo[1] = 8; w[1] = 10;
            end
            2'd2: begin
                n = 4;
                lo[0] = 0;  w[0] = 4;
                lo[1] = 4;  w[1] = 4;
                lo[2] = 8;  w[2] = 6;
                lo[3] = 14; w[3] = 4;
            end
            default: begin
                n = 1;
                lo[0] = 0; w[0] = 18;
            end
        endcase
        acc = 0;
        for (int i = 0; i < n; i++) begin
            f = (int'(d) >> lo[i]) & ((1 << w[i]) - 1);
            if (s && f >= (1 << (w[i] - 1))) f = f - (1 << w[i]);
            acc = acc + f;
            b.data = 18'(f);
            b.lane = 2'(i);
            b.last = (i == n - 1);
            b.sum  = 20'(acc);
            q.push_back(b);
        end
        if (m == 2'd3) err_m = 1'b1;
    endtask

    task automatic cycle(input bit iv, input logic [17:0] d, input logic [1:0] m,
                         input bit s, input bit ordy);
        bit exp_valid;
        bit exp_ready;
        in_valid  = iv;
        in_data   = d;
        in_mode   = m;
        in_sign   = s;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() > 0);
        exp_ready = !exp_valid || (q[0].last && ordy);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("err_mode", 32'(err_mode), 32'(err_m));
        if (exp_valid) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_lane", 32'(out_lane), 32'(q[0].lane));
            chk("out_last", 32'(out_last), 32'(q[0].last));
`ifdef UNPACKER_LANE_SUM_EN
            if (q[0].last) chk("out_sum", 32'(out_sum), 32'(q[0].sum));
`endif
        end
        @(posedge clk);
        if (exp_valid && ordy) void'(q.pop_front());
        if (iv && exp_ready) push_word(d, m, s);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_lane", 32'(out_lane), 32'd0);
            chk("rst_out_last", 32'(out_last), 32'd0);
            chk("rst_err_mode", 32'(err_mode), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef UNPACKER_LANE_SUM_EN
            chk("rst_out_sum", 32'(out_sum), 32'd0);
`endif
        end
        q.delete();
        err_m = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_sign   = 1'b0;
        out_ready = 1'b0;
        err_m     = 1'b0;
        do_reset(2);

        // full-width signed word
        cycle(1, 18'h3FFFF, 2'd0, 1, 1);
        cycle(0, 18'h0, 2'd0, 0, 1);
        cycle(0, 18'h0, 2'd0, 0, 1);

        // two-lane signed word
        cycle(1, 18'h019F7, 2'd1, 1, 1);
        repeat (3) cycle(0, 18'h0, 2'd0, 0, 1);

        // four-lane word, unsigned then signed
        cycle(1, 18'h33149, 2'd2, 0, 1);
        repeat (5) cycle(0, 18'h0, 2'd0, 0, 1);
        cycle(1, 18'h33149, 2'd2, 1, 1);
        repeat (5) cycle(0, 18'h0, 2'd0, 0, 1);

        // back-to-back: ignored input changes until the last beat of the first word
        cycle(1, 18'h33149, 2'd2, 1, 1);
        repeat (3) cycle(1, 18'($urandom), 2'($urandom), 1'($urandom), 1);
        cycle(1, 18'h2A5C3, 2'd2, 0, 1);
        repeat (4) cycle(0, 18'h0, 2'd0, 0, 1);
        cycle(0, 18'h0, 2'd0, 0, 1);

        // stall at lane 1 for three cycles
        cycle(1, 18'h1B3E7, 2'd2, 1, 1);
        cycle(0, 18'h0, 2'd0, 0, 1);
        repeat (3) cycle(1, 18'($urandom), 2'($urandom), 1'($urandom), 0);
        repeat (4) cycle(0, 18'h0, 2'd0, 0, 1);

        // reset while lane 2 is on the bus
        cycle(1, 18'h0F0F5, 2'd2, 1, 1);
        cycle(0, 18'h0, 2'd0, 0, 1);
        cycle(0, 18'h0, 2'd0, 0, 1);
        do_reset(1);
        cycle(1, 18'h12345, 2'd2, 0, 1);
        repeat (5) cycle(0, 18'h0, 2'd0, 0, 1);

        // reserved mode
        cycle(1, 18'h00005, 2'd3, 0, 1);
        repeat (3) cycle(0, 18'h0, 2'd0, 0, 1);

        // random traffic
        repeat (500) begin
            cycle(1'($urandom_range(0, 1)), 18'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (6) cycle(0, 18'h0, 2'd0, 0, 1);
        do_reset(1);
        cycle(0, 18'h0, 2'd0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
